reflet_ram16_arbiter: RTL and testbench

Two-port arbiter that shares one `reflet_ram16` byte-addressable 16-bit RAM between two requesters: port 0 (instruction fetch) and port 1 (data load/store). It serialises accesses through a three-state sequencer and holds each requester's address, data and write flag stable for the RAM. It returns read data in a registered result with a one-cycle acknowledge pulse. It sits between the CPU bus masters and the RAM instance.

---
 rtl/reflet_ram16_arbiter_pkg.sv | 13 +
 rtl/reflet_ram16_arbiter_if.sv | 38 +++
 rtl/reflet_ram16_arbiter_pick2.sv | 41 ++++
 rtl/reflet_ram16_arbiter.sv | 117 +++++++++++
 tb/tb_reflet_ram16_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/reflet_ram16_arbiter_pkg.sv
// Shared state encodings and port identifiers for the reflet_ram16 two-port arbiter.
package reflet_ram16_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LATCH = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/reflet_ram16_arbiter_if.sv
// Requester and RAM-side signal bundle for the reflet_ram16 arbiter.
interface reflet_ram16_arbiter_if #(
    parameter int unsigned addrSize = 9
);
    logic                req0;
    logic                req1;
    logic [addrSize-1:0] addr0;
    logic [addrSize-1:0] addr1;
    logic [15:0]         wdata0;
    logic [15:0]         wdata1;
    logic                wen0;
    logic                wen1;
    logic                ack0;
    logic                ack1;
    logic [15:0]         rdata0;
    logic [15:0]         rdata1;
    logic                ram_enable;
    logic [addrSize-1:0] ram_addr;
    logic [15:0]         ram_data_in;
    logic                ram_write_en;
    logic [15:0]         ram_data_out;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, wen0, wen1, ram_data_out,
        output ack0, ack1, rdata0, rdata1, ram_enable, ram_addr, ram_data_in, ram_write_en
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, wen0, wen1,
        input  ack0, ack1, rdata0, rdata1
    );

    modport mem (
        input  ram_enable, ram_addr, ram_data_in, ram_write_en,
        output ram_data_out
    );

endinterface

// File: rtl/reflet_ram16_arbiter_pick2.sv
// Two-way winner select; with REFLET_RAM16_ARB_ROUND_ROBIN_EN it also owns the priority pointer.
module reflet_arb_pick2
    import reflet_ram16_arb_pkg::*;
(
`ifdef REFLET_RAM16_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       reset,
    input  logic       take,
`endif
    input  logic [1:0] cand,
    output logic       valid,
    output logic       winner
);

    assign valid = |cand;

`ifdef REFLET_RAM16_ARB_ROUND_ROBIN_EN
    logic ptr;

    always_comb begin
        winner = PORT0;
        if (&cand)
            winner = ptr;
        else if (cand[1])
            winner = PORT1;
    end

    // Pointer moves only when a conflict is actually resolved.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= PORT0;
        else if (take && (&cand))
            ptr <= ~ptr;
    end
`else
    always_comb begin
        winner = cand[0] ? PORT0 : PORT1;
    end
`endif

endmodule

// File: rtl/reflet_ram16_arbiter.sv
// Shares one reflet_ram16 between fetch (port 0) and data (port 1) through an IDLE/ISSUE/LATCH sequencer.
// Build option: REFLET_RAM16_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
module reflet_ram16_arbiter
    import reflet_ram16_arb_pkg::*;
#(
    parameter int unsigned addrSize = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    reflet_ram16_arbiter_if.slave bus
);

    arb_state_t          state;
    logic [1:0]          cand;
    logic                grant_valid;
    logic                grant_id;
    logic                lat_id;
    logic                lat_wen;
    logic                ack0_q;
    logic                ack1_q;
    logic [15:0]         rdata0_q;
    logic [15:0]         rdata1_q;
    logic                ram_en_q;
    logic                ram_we_q;
    logic [addrSize-1:0] ram_addr_q;
    logic [15:0]         ram_din_q;
    logic [addrSize-1:0] pick_addr;
    logic [15:0]         pick_wdata;
    logic                pick_wen;

    // A port whose ack is high this cycle is still holding its old request.
    assign cand = {bus.req1 & ~ack1_q, bus.req0 & ~ack0_q};

    reflet_arb_pick2 u_pick (
`ifdef REFLET_RAM16_ARB_ROUND_ROBIN_EN
        .clk    (clk),
        .reset  (reset),
        .take   (state == IDLE),
`endif
        .cand   (cand),
        .valid  (grant_valid),
        .winner (grant_id)
    );

    always_comb begin
        pick_addr  = bus.addr0;
        pick_wdata = bus.wdata0;
        pick_wen   = bus.wen0;
        if (grant_id == PORT1) begin
            pick_addr  = bus.addr1;
            pick_wdata = bus.wdata1;
            pick_wen   = bus.wen1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lat_id     <= PORT0;
            lat_wen    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_id     <= grant_id;
                        lat_wen    <= pick_wen;
                        ram_en_q   <= 1'b1;
                        ram_we_q   <= pick_wen;
                        ram_addr_q <= pick_addr;
                        ram_din_q  <= pick_wdata;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_en_q   <= 1'b0;
                    ram_we_q   <= 1'b0;
                    ram_addr_q <= '0;
                    ram_din_q  <= '0;
                    state      <= LATCH;
                end
                LATCH: begin
                    if (lat_id == PORT1) begin
                        ack1_q <= 1'b1;
                        if (!lat_wen)
                            rdata1_q <= bus.ram_data_out;
                    end else begin
                        ack0_q <= 1'b1;
                        if (!lat_wen)
                            rdata0_q <= bus.ram_data_out;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack0         = ack0_q;
    assign bus.ack1         = ack1_q;
    assign bus.rdata0       = rdata0_q;
    assign bus.rdata1       = rdata1_q;
    assign bus.ram_enable   = ram_en_q;
    assign bus.ram_write_en = ram_we_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_data_in  = ram_din_q;

endmodule

// File: tb/tb_reflet_ram16_arbiter.sv
// Directed bench for reflet_ram16_arbiter with a behavioural registered-read RAM attached.
module tb_reflet_ram16_arbiter;

    localparam int unsigned AW = 9;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mem_clr = 1'b1;

    always #5 clk = ~clk;

    reflet_ram16_arbiter_if #(.addrSize(AW)) bus ();

    reflet_ram16_arbiter #(.addrSize(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM: data registered on the enable edge, visible the following cycle.
    logic [15:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            bus.ram_data_out <= '0;
        end else if (bus.ram_enable) begin
            if (bus.ram_write_en) mem[bus.ram_addr] <= bus.ram_data_in;
            bus.ram_data_out <= mem[bus.ram_addr];
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          port;
        logic        wen;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic access(input int port, input logic wen, input logic [AW-1:0] addr,
                          input logic [15:0] wdata, output int lat, output logic en1,
                          output logic we1, output logic en2, output logic other_ack);
        if (port == 1) begin
            bus.addr1 = addr; bus.wdata1 = wdata; bus.wen1 = wen; bus.req1 = 1'b1;
        end else begin
            bus.addr0 = addr; bus.wdata0 = wdata; bus.wen0 = wen; bus.req0 = 1'b1;
        end
        lat = -1; en1 = 1'b0; we1 = 1'b0; en2 = 1'b0; other_ack = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin en1 = bus.ram_enable; we1 = bus.ram_write_en; end
            if (c == 2) en2 = bus.ram_enable;
            if ((port == 1) ? bus.ack0 : bus.ack1) other_ack = 1'b1;
            if ((port == 1) ? bus.ack1 : bus.ack0) begin lat = c; break; end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic pair(input int exp_t0, input int exp_t1, input string tag);
        int t0, t1;
        t0 = -1; t1 = -1;
        bus.addr0 = 9'h000; bus.wen0 = 1'b0; bus.req0 = 1'b1;
        bus.addr1 = 9'h002; bus.wen1 = 1'b0; bus.req1 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (bus.ack0) begin t0 = c; bus.req0 = 1'b0; end
            if (bus.ack1) begin t1 = c; bus.req1 = 1'b0; end
            if (t0 > 0 && t1 > 0) break;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk({tag, "_ack0_cycle"}, t0, exp_t0);
        chk({tag, "_ack1_cycle"}, t1, exp_t1);
        chk({tag, "_rdata0"}, bus.rdata0, 16'h5678);
        chk({tag, "_rdata1"}, bus.rdata1, 16'hCAFE);
        tick();
    endtask

    initial begin
        int lat;
        logic en1, we1, en2, oth;
        logic [31:0] ack_mask, en_mask;

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        bus.wen0 = 1'b0; bus.wen1 = 1'b0;

        vecs[0] = '{1, 1'b1, 9'h011, 16'hBEEF, 16'h0000};
        vecs[1] = '{1, 1'b0, 9'h011, 16'h0000, 16'hBEEF};
        vecs[2] = '{0, 1'b0, 9'h011, 16'h0000, 16'hBEEF};
        vecs[3] = '{0, 1'b1, 9'h000, 16'h1234, 16'hBEEF};
        vecs[4] = '{0, 1'b0, 9'h000, 16'h0000, 16'h1234};
        vecs[5] = '{0, 1'b1, 9'h000, 16'h5678, 16'h1234};
        vecs[6] = '{0, 1'b0, 9'h000, 16'h0000, 16'h5678};
        vecs[7] = '{1, 1'b1, 9'h1FF, 16'hA5A5, 16'hBEEF};
        vecs[8] = '{0, 1'b1, 9'h002, 16'hCAFE, 16'h5678};
        vecs[9] = '{1, 1'b0, 9'h002, 16'h0000, 16'hCAFE};

        repeat (3) tick();
        chk("rst_ack0", bus.ack0, 1'b0);
        chk("rst_ack1", bus.ack1, 1'b0);
        chk("rst_rdata0", bus.rdata0, 16'h0000);
        chk("rst_rdata1", bus.rdata1, 16'h0000);
        chk("rst_ram_enable", bus.ram_enable, 1'b0);
        chk("rst_ram_write_en", bus.ram_write_en, 1'b0);
        mem_clr = 1'b0;
        reset = 1'b1;
        tick();

        for (int v = 0; v < 10; v++) begin
            access(vecs[v].port, vecs[v].wen, vecs[v].addr, vecs[v].wdata, lat, en1, we1, en2, oth);
            chk($sformatf("v%0d_latency", v), lat, 3);
            chk($sformatf("v%0d_issue_enable", v), en1, 1'b1);
            chk($sformatf("v%0d_issue_write_en", v), we1, vecs[v].wen);
            chk($sformatf("v%0d_latch_enable", v), en2, 1'b0);
            chk($sformatf("v%0d_other_ack", v), oth, 1'b0);
            chk($sformatf("v%0d_rdata", v), (vecs[v].port == 1) ? bus.rdata1 : bus.rdata0,
                vecs[v].exp_rdata);
            tick();
        end

        pair(3, 6, "pair1");
`ifdef REFLET_RAM16_ARB_ROUND_ROBIN_EN
        pair(6, 3, "pair2");
`else
        pair(3, 6, "pair2");
`endif

        // Held request: grants at 1,5,9 and acks at 3,7,11 within 12 cycles.
        ack_mask = '0; en_mask = '0;
        bus.addr0 = 9'h011; bus.wen0 = 1'b0; bus.req0 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.ack0) ack_mask[c] = 1'b1;
            if (bus.ram_enable) en_mask[c] = 1'b1;
        end
        bus.req0 = 1'b0;
        chk("held_ack_cycles", ack_mask, 32'h0000_0888);
        chk("held_enable_cycles", en_mask, 32'h0000_0222);
        chk("held_rdata0", bus.rdata0, 16'hBEEF);
        tick();
        tick();

        // Reset during LATCH: access dropped, then reissued after release.
        bus.addr0 = 9'h000; bus.wen0 = 1'b0; bus.req0 = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_ack0", bus.ack0, 1'b0);
        chk("midrst_rdata0", bus.rdata0, 16'h0000);
        chk("midrst_ram_enable", bus.ram_enable, 1'b0);
        tick();
        tick();
        chk("midrst_no_ack", bus.ack0, 1'b0);
        reset = 1'b1;
        access(0, 1'b0, 9'h000, 16'h0000, lat, en1, we1, en2, oth);
        chk("reissue_latency", lat, 3);
        chk("reissue_rdata0", bus.rdata0, 16'h5678);
        chk("reissue_rdata1_cleared", bus.rdata1, 16'h0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
